// File: rtl/decode_stage_reg.sv
// Registered MIPS decode stage: field split, R/I/J classification, immediate and jump-target
// generation, write-back register selection. Load-use hazard bubbles are built with DECODE_HAZARD_EN.
module decode_stage_reg #(
    parameter int INSTR_W = 32,
    parameter int OP_W    = 6,
    parameter int REG_AW  = 5,
    parameter int SH_W    = 5,
    parameter int FN_W    = 6,
    parameter int IMM_W   = 16,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_mem_read,
    input  logic [REG_AW-1:0]  ex_rt,
    output logic               hazard_stall,
    output logic               out_valid,
    output logic [OP_W-1:0]    opcode,
    output logic [REG_AW-1:0]  rs,
    output logic [REG_AW-1:0]  rt,
    output logic [REG_AW-1:0]  rd,
    output logic [SH_W-1:0]    shamt,
    output logic [FN_W-1:0]    funct,
    output logic [1:0]         itype,
    output logic [DATA_W-1:0]  imm_ext,
    output logic [DATA_W-1:0]  jump_target,
    output logic [REG_AW-1:0]  dst_reg,
    output logic               reg_write,
    output logic [DATA_W-1:0]  out_pc,
    output logic [CNT_W-1:0]   bubble_cnt
);
    // Handshake: in_valid qualifies in_instr/in_pc; there is no ready. Upstream must hold IF/ID
    // while stall or hazard_stall is high, and out_valid qualifies every registered output.

    localparam logic [1:0] ITYPE_R = 2'd0;
    localparam logic [1:0] ITYPE_I = 2'd1;
    localparam logic [1:0] ITYPE_J = 2'd2;

    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'h0C);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'h0D);
    localparam logic [OP_W-1:0] OP_XORI = OP_W'(6'h0E);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'h0F);
    localparam logic [FN_W-1:0] FN_JR   = FN_W'(6'h08);

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [SH_W-1:0]   shamt;
        logic [FN_W-1:0]   funct;
        logic [1:0]        itype;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] jump_target;
        logic [REG_AW-1:0] dst_reg;
        logic              reg_write;
        logic [DATA_W-1:0] pc;
    } dec_t;

    logic [OP_W-1:0]   f_op;
    logic [REG_AW-1:0] f_rs;
    logic [REG_AW-1:0] f_rt;
    logic [REG_AW-1:0] f_rd;
    logic [SH_W-1:0]   f_sh;
    logic [FN_W-1:0]   f_fn;
    logic [IMM_W-1:0]  f_imm;
    logic [DATA_W-1:0] pc_plus4;
    logic              is_r;
    logic              is_j;
    logic              hazard_w;
    dec_t              dec_now;

    dec_t              dec_d, dec_q;
    logic              valid_d, valid_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    assign f_op     = in_instr[INSTR_W-1 -: OP_W];
    assign f_rs     = in_instr[INSTR_W-OP_W-1 -: REG_AW];
    assign f_rt     = in_instr[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
    assign f_rd     = in_instr[INSTR_W-OP_W-2*REG_AW-1 -: REG_AW];
    assign f_sh     = in_instr[FN_W +: SH_W];
    assign f_fn     = in_instr[FN_W-1:0];
    assign f_imm    = in_instr[IMM_W-1:0];
    assign pc_plus4 = in_pc + DATA_W'(4);
    assign is_r     = (f_op == '0);
    assign is_j     = (f_op == OP_J) || (f_op == OP_JAL);

    always_comb begin
        dec_now        = '0;
        dec_now.opcode = f_op;
        dec_now.rs     = f_rs;
        dec_now.rt     = f_rt;
        dec_now.rd     = f_rd;
        dec_now.shamt  = f_sh;
        dec_now.funct  = f_fn;
        dec_now.pc     = in_pc;
        dec_now.itype  = is_r ? ITYPE_R : (is_j ? ITYPE_J : ITYPE_I);
        // Upper bits of PC+4 survive; the 26-bit index fills the low 28 bits word-aligned.
        dec_now.jump_target = (pc_plus4 & ({DATA_W{1'b1}} << 28)) | DATA_W'({in_instr[25:0], 2'b00});

        if (f_op == OP_ANDI || f_op == OP_ORI || f_op == OP_XORI) begin
            dec_now.imm_ext = {{(DATA_W-IMM_W){1'b0}}, f_imm};
        end else if (f_op == OP_LUI) begin
            dec_now.imm_ext = DATA_W'(f_imm) << (DATA_W-IMM_W);
        end else begin
            dec_now.imm_ext = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};
        end

        if (is_r) begin
            dec_now.dst_reg   = f_rd;
            dec_now.reg_write = (f_fn != FN_JR);
        end else if ((f_op >= OP_W'(6'h08) && f_op <= OP_W'(6'h0F)) ||
                     (f_op >= OP_W'(6'h20) && f_op <= OP_W'(6'h25))) begin
            dec_now.dst_reg   = f_rt;
            dec_now.reg_write = 1'b1;
        end else if (f_op == OP_JAL) begin
            dec_now.dst_reg   = '1;
            dec_now.reg_write = 1'b1;
        end
    end

`ifdef DECODE_HAZARD_EN
    logic rt_is_src;
    assign rt_is_src = is_r || (f_op == OP_BEQ) || (f_op == OP_BNE) ||
                       (f_op >= OP_W'(6'h28) && f_op <= OP_W'(6'h2B));
    assign hazard_w  = in_valid && ex_mem_read && (ex_rt != '0) &&
                       (((ex_rt == f_rs) && !is_j) || ((ex_rt == f_rt) && rt_is_src));
`else
    logic unused_ok;
    assign hazard_w  = 1'b0;
    assign unused_ok = ^{ex_mem_read, ex_rt};
`endif

    assign hazard_stall = hazard_w;

    always_comb begin
        dec_d   = dec_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            dec_d   = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            dec_d   = dec_q;
        end else if (hazard_w) begin
            dec_d   = '0;
            valid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
            valid_d = in_valid;
            dec_d   = in_valid ? dec_now : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign opcode      = dec_q.opcode;
    assign rs          = dec_q.rs;
    assign rt          = dec_q.rt;
    assign rd          = dec_q.rd;
    assign shamt       = dec_q.shamt;
    assign funct       = dec_q.funct;
    assign itype       = dec_q.itype;
    assign imm_ext     = dec_q.imm_ext;
    assign jump_target = dec_q.jump_target;
    assign dst_reg     = dec_q.dst_reg;
    assign reg_write   = dec_q.reg_write;
    assign out_pc      = dec_q.pc;
    assign bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_decode_stage_reg.sv
// Directed bench for decode_stage_reg (bubble counter narrowed to 2 bits to reach saturation).
module tb_decode_stage_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        stall;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        hazard_stall;
    logic        out_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt, dst_reg;
    logic [5:0]  funct;
    logic [1:0]  itype;
    logic [31:0] imm_ext, jump_target, out_pc;
    logic        reg_write;
    logic [1:0]  bubble_cnt;

`ifdef DECODE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [1:0]  itype;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [4:0]  dst;
        logic        rw;
        logic [31:0] pc;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t hold_e;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] exp_cnt = 2'd0;

    decode_stage_reg #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .stall(stall), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .hazard_stall(hazard_stall), .out_valid(out_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .itype(itype), .imm_ext(imm_ext),
        .jump_target(jump_target), .dst_reg(dst_reg), .reg_write(reg_write), .out_pc(out_pc),
        .bubble_cnt(bubble_cnt)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic exp_t dec(input logic v, input logic [5:0] op, input logic [4:0] rs_e,
                                 input logic [4:0] rt_e, input logic [4:0] rd_e, input logic [4:0] sh_e,
                                 input logic [5:0] fn_e, input logic [1:0] it, input logic [31:0] imm,
                                 input logic [31:0] jt, input logic [4:0] dst, input logic rw,
                                 input logic [31:0] pc);
        exp_t e;
        e = '{valid: v, opcode: op, rs: rs_e, rt: rt_e, rd: rd_e, sh: sh_e, fn: fn_e, itype: it,
              imm: imm, jt: jt, dst: dst, rw: rw, pc: pc, cnt: exp_cnt};
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = '0;
        e.cnt = exp_cnt;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // scoreboard: pop one expectation per clock and compare every output
    task automatic check_out();
        exp_t e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.valid));
        chk("opcode", 32'(opcode), 32'(e.opcode));
        chk("rs", 32'(rs), 32'(e.rs));
        chk("rt", 32'(rt), 32'(e.rt));
        chk("rd", 32'(rd), 32'(e.rd));
        chk("shamt", 32'(shamt), 32'(e.sh));
        chk("funct", 32'(funct), 32'(e.fn));
        chk("itype", 32'(itype), 32'(e.itype));
        chk("imm_ext", imm_ext, e.imm);
        chk("jump_target", jump_target, e.jt);
        chk("dst_reg", 32'(dst_reg), 32'(e.dst));
        chk("reg_write", 32'(reg_write), 32'(e.rw));
        chk("out_pc", out_pc, e.pc);
        chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
    endtask

    // driver: apply inputs, check the combinational hazard flag, then the registered result
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl, input logic mr, input logic [4:0] ert,
                        input logic hz_exp, input exp_t e);
        in_valid    = v;
        in_instr    = ins;
        in_pc       = pc;
        stall       = st;
        flush       = fl;
        ex_mem_read = mr;
        ex_rt       = ert;
        #1;
        chk("hazard_stall", 32'(hazard_stall), 32'(hz_exp));
        exp_q.push_back(e);
        check_out();
    endtask

    initial begin
        exp_t add_e;
        rst = 1'b1;
        step(1, 32'h8C880004, 32'h0, 0, 0, 0, 5'd0, 0, bub());
        step(1, 32'h8C880004, 32'h0, 0, 0, 0, 5'd0, 0, bub());
        rst = 1'b0;

        step(1, 32'h8C880004, 32'h100, 0, 0, 0, 5'd0, 0,
             dec(1, 6'h23, 4, 8, 0, 0, 6'h04, 1, 32'h4, 32'h02200010, 8, 1, 32'h100));
        step(1, 32'h2022FFFF, 32'h104, 0, 0, 0, 5'd0, 0,
             dec(1, 6'h08, 1, 2, 31, 31, 6'h3F, 1, 32'hFFFFFFFF, 32'h008BFFFC, 2, 1, 32'h104));
        step(1, 32'h3422FFFF, 32'h108, 0, 0, 0, 5'd0, 0,
             dec(1, 6'h0D, 1, 2, 31, 31, 6'h3F, 1, 32'h0000FFFF, 32'h008BFFFC, 2, 1, 32'h108));
        step(1, 32'h3C011234, 32'h10C, 0, 0, 0, 5'd0, 0,
             dec(1, 6'h0F, 0, 1, 2, 8, 6'h34, 1, 32'h12340000, 32'h000448D0, 1, 1, 32'h10C));
        hold_e = dec(1, 6'h03, 0, 0, 0, 0, 6'h10, 2, 32'h10, 32'h40000040, 31, 1, 32'h40000000);
        step(1, 32'h0C000010, 32'h40000000, 0, 0, 0, 5'd0, 0, hold_e);

        // stall holds, including over a hazard-causing instruction
        step(1, 32'h2022FFFF, 32'h500, 1, 0, 0, 5'd0, 0, hold_e);
        step(1, 32'h01084820, 32'h504, 1, 0, 1, 5'd8, HZ, hold_e);
        step(1, 32'h3C011234, 32'h508, 1, 0, 0, 5'd0, 0, hold_e);
        step(1, 32'h3C011234, 32'h508, 1, 1, 0, 5'd0, 0, bub());

        // load-use hazard on add $9,$8,$8
        if (HZ) exp_cnt = 2'd1;
        add_e = dec(1, 6'h00, 8, 8, 9, 0, 6'h20, 0, 32'h4820, 32'h04212080, 9, 1, 32'h200);
        add_e.cnt = exp_cnt;
        step(1, 32'h01084820, 32'h200, 0, 0, 1, 5'd8, HZ, HZ ? bub() : add_e);
        step(1, 32'h01084820, 32'h200, 0, 0, 0, 5'd8, 0, add_e);
        step(1, 32'h01084820, 32'h200, 0, 0, 1, 5'd0, 0, add_e);

        // lw: rt is a destination, rs is a source
        step(1, 32'h8C880004, 32'h100, 0, 0, 1, 5'd8, 0,
             dec(1, 6'h23, 4, 8, 0, 0, 6'h04, 1, 32'h4, 32'h02200010, 8, 1, 32'h100));
        if (HZ) exp_cnt = 2'd2;
        step(1, 32'h8C880004, 32'h100, 0, 0, 1, 5'd4, HZ,
             HZ ? bub() : dec(1, 6'h23, 4, 8, 0, 0, 6'h04, 1, 32'h4, 32'h02200010, 8, 1, 32'h100));
        // J ignores its rs field and does not write
        step(1, 32'h08800000, 32'h300, 0, 0, 1, 5'd4, 0,
             dec(1, 6'h02, 4, 0, 0, 0, 6'h00, 2, 32'h0, 32'h02000000, 0, 0, 32'h300));

        // five consecutive hazards: counter saturates at 3
        if (HZ) exp_cnt = 2'd3;
        step(1, 32'h10880003, 32'h304, 0, 0, 1, 5'd8, HZ,
             HZ ? bub() : dec(1, 6'h04, 4, 8, 0, 0, 6'h03, 1, 32'h3, 32'h0220000C, 0, 0, 32'h304));
        step(1, 32'hAC880004, 32'h308, 0, 0, 1, 5'd8, HZ,
             HZ ? bub() : dec(1, 6'h2B, 4, 8, 0, 0, 6'h04, 1, 32'h4, 32'h02200010, 0, 0, 32'h308));
        add_e.cnt = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h01084820, 32'h200, 0, 0, 1, 5'd8, HZ, HZ ? bub() : add_e);
        end

        // jr writes nothing; undefined opcode writes nothing; in_valid=0 gives a bubble
        step(1, 32'h03E00008, 32'h400, 0, 0, 0, 5'd0, 0,
             dec(1, 6'h00, 31, 0, 0, 0, 6'h08, 0, 32'h8, 32'h0F800020, 0, 0, 32'h400));
        step(1, 32'hFC000000, 32'h500, 0, 0, 0, 5'd0, 0,
             dec(1, 6'h3F, 0, 0, 0, 0, 6'h00, 1, 32'h0, 32'h0, 0, 0, 32'h500));
        step(0, 32'h8C880004, 32'h100, 0, 0, 0, 5'd0, 0, bub());

        // reset during stall clears everything, counter included
        step(1, 32'h8C880004, 32'h100, 0, 0, 0, 5'd0, 0,
             dec(1, 6'h23, 4, 8, 0, 0, 6'h04, 1, 32'h4, 32'h02200010, 8, 1, 32'h100));
        rst = 1'b1;
        exp_cnt = 2'd0;
        step(1, 32'h2022FFFF, 32'h104, 1, 0, 0, 5'd0, 0, bub());
        rst = 1'b0;

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage_reg.md
Name: decode_stage_reg

Overview:
Parametrised, registered instruction-decode stage for the pipelined MIPS core. It sits between IF/ID and ID/EX.
- Splits the fetched instruction into fields and classifies it (R/I/J).
- Produces the extended immediate, jump target, destination register and write-enable.
- Holds results in a pipeline register with valid/stall/flush control.
- Optionally detects load-use hazards and inserts bubbles.

Parameters:
- INSTR_W, 32, instruction width; must equal OP_W+3*REG_AW+SH_W+FN_W.
- OP_W, 6, opcode width (top bits of instruction).
- REG_AW, 5, register-address width.
- SH_W, 5, shift-amount width.
- FN_W, 6, funct width (low bits).
- IMM_W, 16, immediate width (low bits).
- DATA_W, 32, PC/immediate output width; must be at least 28 and greater than IMM_W.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_instr/in_pc valid.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  DATA_W  PC of in_instr.
- stall  in  1  hold the output register.
- flush  in  1  replace the output with a bubble.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_rt  in  REG_AW  ID/EX load destination.
- hazard_stall  out  1  combinational; upstream must hold IF/ID when high.
- out_valid  out  1  registered outputs valid.
- opcode  out  OP_W
- rs  out  REG_AW
- rt  out  REG_AW
- rd  out  REG_AW
- shamt  out  SH_W
- funct  out  FN_W
- itype  out  2  0=R, 1=I, 2=J.
- imm_ext  out  DATA_W  extended immediate.
- jump_target  out  DATA_W
- dst_reg  out  REG_AW  write-back register.
- reg_write  out  1  instruction writes dst_reg.
- out_pc  out  DATA_W
- bubble_cnt  out  CNT_W  hazard bubbles inserted; saturates.

Behaviour:
Field extraction (MSB to LSB):
- opcode, rs, rt, rd, shamt, funct in that order.
- imm = low IMM_W bits.
- Defaults give the standard MIPS split.

Classification:
- itype: opcode==0 → R; opcode 0x02/0x03 → J; all others → I.

imm_ext:
- ANDI/ORI/XORI (0x0C/0x0D/0x0E): zero-extend.
- LUI (0x0F): imm << (DATA_W-IMM_W), low bits zero.
- All others: sign-extend.

jump_target:
- {(in_pc+4)[DATA_W-1:28], instr[25:0], 2'b00}.
- Addition wraps modulo 2^DATA_W.

dst_reg / reg_write:
- R-type: dst_reg=rd; reg_write=1, except funct 0x08 (JR) → 0.
- Opcodes 0x08–0x0F and loads 0x20–0x25: dst_reg=rt, reg_write=1.
- JAL (0x03): dst_reg=all-ones (31), reg_write=1.
- Stores 0x28–0x2B, branches 0x04–0x07, J (0x02), undefined opcodes: reg_write=0, dst_reg=0.
- reg_write is forced 0 whenever the captured entry is a bubble.

Register update at posedge clk, priority order:
1. rst: every output register 0, including out_valid, bubble_cnt and out_pc.
2. flush: bubble — out_valid=0, all decoded fields 0; bubble_cnt unchanged.
3. stall: hold all outputs.
4. hazard_stall: bubble; bubble_cnt increments, saturating at 2^CNT_W-1.
5. Otherwise: capture decoded in_instr/in_pc; out_valid=in_valid; fields zeroed when in_valid=0.

Timing and corner cases:
- Latency: one cycle from in_instr to outputs.
- hazard_stall is combinational, from in_instr/in_valid/ex_* only.
- flush with stall in the same cycle: flush wins.
- hazard with stall=1: hold; counter unchanged.
- rst mid-stall: clears everything.

Optional Feature:
Macro DECODE_HAZARD_EN.

Defined, hazard_stall = in_valid && ex_mem_read && ex_rt!=0 && any of:
- ex_rt==rs, for any type except J;
- ex_rt==rt, where rt is a source: R-type, BEQ/BNE (0x04/0x05), or stores.

Undefined:
- hazard_stall tied 0.
- ex_mem_read/ex_rt ignored.
- bubble_cnt constant 0.

Test Plan:
- rst=1 for 2 cycles with in_instr=0x8C880004 → all outputs 0, out_valid=0, bubble_cnt=0.
- Load 0x8C880004 (lw $8,4($4)), in_pc=0x100 → next cycle: opcode=0x23, rs=4, rt=8, itype=1, imm_ext=0x00000004, dst_reg=8, reg_write=1, out_pc=0x100.
- Extension cases, one per cycle:
  - 0x2022FFFF → imm_ext 0xFFFFFFFF.
  - 0x3422FFFF → 0x0000FFFF.
  - 0x3C011234 → 0x12340000.
  - 0x0C000010 with in_pc=0x40000000 → itype=2, jump_target=0x40000040, dst_reg=31, reg_write=1.
- stall=1 for 3 cycles while in_instr changes → outputs frozen. Assert flush and stall together → out_valid=0, reg_write=0.
- DECODE_HAZARD_EN: ex_mem_read=1, ex_rt=8, in_instr=0x01084820 (add $9,$8,$8) → hazard_stall=1, bubble next cycle, bubble_cnt=1. Then ex_mem_read=0 → capture rd=9, funct=0x20, reg_write=1. Repeat with ex_rt=0 → no hazard.
- Bubble counter with CNT_W=2: force 5 consecutive hazards → bubble_cnt saturates at 3.
